// File: rtl/sram_controller_if.sv
// Bus between the MEM pipeline stage, the SRAM controller and the external 16-bit SRAM.
// The master side is the pipeline/SRAM environment; the slave side is the controller.
interface sram_controller_if;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] address;
   logic [31:0] data;
   logic [31:0] mem_result;
   logic        ready;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out;
   logic        sram_dq_oe;
   logic [15:0] sram_dq_in;
   logic        sram_we_n;

   modport master (
      output mem_read, mem_write, address, data, sram_dq_in,
      input  mem_result, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
   );

   modport slave (
      input  mem_read, mem_write, address, data, sram_dq_in,
      output mem_result, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
   );
endinterface

// File: rtl/sram_controller.sv
// 32-bit load/store controller over a 16-bit SRAM: low half then high half, WAIT_CYCLES each.
// Optional single-entry read buffer enabled by macro SRAM_READ_CACHE_EN.
module sram_controller #(
   parameter int WAIT_CYCLES = 2
) (
   input logic            clk,
   input logic            rst,
   sram_controller_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

   localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic [31:0] result, result_nxt;
   logic        req, is_write, is_read, last, hit;
   logic [16:0] idx;
   logic [31:0] hit_data;
   logic        unused;

   // Request is not latched: upstream holds it stable until ready.
   assign req      = bus.mem_read | bus.mem_write;
   assign is_write = bus.mem_write;
   assign is_read  = bus.mem_read & ~bus.mem_write;
   assign idx      = bus.address[18:2];
   assign last     = (cnt >= LAST);
   assign unused   = ^{bus.address[31:19], bus.address[1:0]};
   assign bus.mem_result = result;

`ifdef SRAM_READ_CACHE_EN
   logic        buf_vld, buf_vld_nxt;
   logic [16:0] buf_tag, buf_tag_nxt;
   logic [31:0] buf_data, buf_data_nxt;

   assign hit      = is_read & buf_vld & (buf_tag == idx);
   assign hit_data = buf_data;

   always_comb begin
      buf_vld_nxt  = buf_vld;
      buf_tag_nxt  = buf_tag;
      buf_data_nxt = buf_data;
      if (state == HIGH && last) begin
         if (is_read) begin
            buf_vld_nxt  = 1'b1;
            buf_tag_nxt  = idx;
            buf_data_nxt = {bus.sram_dq_in, result[15:0]};
         end else if (is_write && buf_vld && buf_tag == idx) begin
            buf_data_nxt = bus.data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         buf_vld  <= 1'b0;
         buf_tag  <= '0;
         buf_data <= '0;
      end else begin
         buf_vld  <= buf_vld_nxt;
         buf_tag  <= buf_tag_nxt;
         buf_data <= buf_data_nxt;
      end
   end
`else
   assign hit      = 1'b0;
   assign hit_data = '0;
`endif

   always_comb begin
      state_nxt       = state;
      cnt_nxt         = cnt + 4'd1;
      result_nxt      = result;
      bus.ready       = 1'b0;
      bus.sram_we_n   = 1'b1;
      bus.sram_dq_oe  = 1'b0;
      bus.sram_addr   = '0;
      bus.sram_dq_out = '0;
      case (state)
         IDLE: begin
            cnt_nxt   = '0;
            bus.ready = ~req;
            if (hit) begin
               state_nxt  = DONE;
               result_nxt = hit_data;
            end else if (req) begin
               state_nxt = LOW;
            end
         end
         LOW: begin
            bus.sram_addr = {idx, 1'b0};
            if (is_write) begin
               bus.sram_we_n   = 1'b0;
               bus.sram_dq_oe  = 1'b1;
               bus.sram_dq_out = bus.data[15:0];
            end
            if (last) begin
               state_nxt = HIGH;
               cnt_nxt   = '0;
               if (is_read) result_nxt[15:0] = bus.sram_dq_in;
            end
         end
         HIGH: begin
            bus.sram_addr = {idx, 1'b1};
            if (is_write) begin
               bus.sram_we_n   = 1'b0;
               bus.sram_dq_oe  = 1'b1;
               bus.sram_dq_out = bus.data[31:16];
            end
            if (last) begin
               state_nxt = DONE;
               cnt_nxt   = '0;
               if (is_read) result_nxt[31:16] = bus.sram_dq_in;
            end
         end
         default: begin
            bus.ready = 1'b1;
            cnt_nxt   = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         cnt    <= '0;
         result <= '0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         result <= result_nxt;
      end
   end
endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: vector table with scoreboarded load results,
// plus reset-abort and dropped-request sequences against a behavioural SRAM.
module tb_sram_controller;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   sram_controller_if bus ();
   sram_controller #(.WAIT_CYCLES(2)) dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef SRAM_READ_CACHE_EN
   localparam int HIT_LAT = 1;
   localparam int HIT_ACT = 0;
`else
   localparam int HIT_LAT = 5;
   localparam int HIT_ACT = 4;
`endif

   logic [15:0] sram_mem [0:255];
   always_comb bus.sram_dq_in = sram_mem[bus.sram_addr[7:0]];
   always @(posedge clk) if (!bus.sram_we_n) sram_mem[bus.sram_addr[7:0]] <= bus.sram_dq_out;

   typedef struct {
      logic        w;
      logic        r;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] res;
      int          lat;
      int          act;
   } vec_t;

   vec_t        vt [10];
   logic [31:0] exp_q [$];
   logic [17:0] addr_q [$];
   logic [15:0] dq_q [$];
   int          errors = 0;
   int          checks = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Called just after a rising edge; that cycle is cycle 0 of the access.
   task automatic run(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_res, output int lat, output int act);
      bit done = 0;
      exp_q.push_back(exp_res);
      addr_q.delete();
      dq_q.delete();
      bus.mem_write = w;
      bus.mem_read  = r;
      bus.address   = a;
      bus.data      = d;
      lat = -1;
      act = 0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (!bus.sram_we_n || bus.sram_addr != 18'd0) act++;
         if (!bus.sram_we_n) begin
            addr_q.push_back(bus.sram_addr);
            dq_q.push_back(bus.sram_dq_out);
         end
         if (bus.ready) begin
            done = 1;
            lat  = c;
            chk("mem_result", 64'(bus.mem_result), 64'(exp_q.pop_front()));
         end
         @(posedge clk);
         #1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL timeout: got no ready expected ready within 40 cycles");
      end
      bus.mem_write = 1'b0;
      bus.mem_read  = 1'b0;
   endtask

   initial begin
      int  lat, act;
      bit  seen;
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      bus.address   = '0;
      bus.data      = '0;

      vt[0] = '{1'b1, 1'b0, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0000_0000, 5, 4};
      vt[1] = '{1'b0, 1'b1, 32'h0000_0008, 32'h0,         32'hDEAD_BEEF, 5, 4};
      vt[2] = '{1'b0, 1'b1, 32'h0000_0008, 32'h0,         32'hDEAD_BEEF, HIT_LAT, HIT_ACT};
      vt[3] = '{1'b1, 1'b0, 32'h0000_0008, 32'h1234_5678, 32'hDEAD_BEEF, 5, 4};
      vt[4] = '{1'b0, 1'b1, 32'h0000_0008, 32'h0,         32'h1234_5678, HIT_LAT, HIT_ACT};
      vt[5] = '{1'b1, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 32'h1234_5678, 5, 4};
      vt[6] = '{1'b0, 1'b1, 32'h0000_0010, 32'h0,         32'hCAFE_F00D, 5, 4};
      vt[7] = '{1'b0, 1'b1, 32'h0000_0008, 32'h0,         32'h1234_5678, 5, 4};
      vt[8] = '{1'b1, 1'b0, 32'h0007_FFFF, 32'hA5A5_5A5A, 32'h1234_5678, 5, 4};
      vt[9] = '{1'b0, 1'b1, 32'h8007_FFFC, 32'h0,         32'hA5A5_5A5A, 5, 4};

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready",  64'(bus.ready), 64'd1);
      chk("rst_we_n",   64'(bus.sram_we_n), 64'd1);
      chk("rst_oe",     64'(bus.sram_dq_oe), 64'd0);
      chk("rst_addr",   64'(bus.sram_addr), 64'd0);
      chk("rst_dq_out", 64'(bus.sram_dq_out), 64'd0);
      chk("rst_result", 64'(bus.mem_result), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      for (int i = 0; i < 10; i++) begin
         run(vt[i].w, vt[i].r, vt[i].a, vt[i].d, vt[i].res, lat, act);
         chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vt[i].lat));
         chk($sformatf("v%0d_sram_cycles", i), 64'(act), 64'(vt[i].act));
         if (i == 0) begin
            chk("wr_addr_lo", 64'(addr_q[0]), 64'd4);
            chk("wr_addr_hi", 64'(addr_q[3]), 64'd5);
            chk("wr_dq_lo",   64'(dq_q[0]), 64'hBEEF);
            chk("wr_dq_hi",   64'(dq_q[3]), 64'hDEAD);
         end
         if (i == 1) begin
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               chk("hold_result", 64'(bus.mem_result), 64'hDEAD_BEEF);
               chk("idle_ready",  64'(bus.ready), 64'd1);
            end
            @(posedge clk);
            #1;
         end
         if (i == 5) chk("both_we_cycles", 64'(addr_q.size()), 64'd4);
         if (i == 8) begin
            chk("max_addr_lo", 64'(addr_q[0]), 64'h3FFFE);
            chk("max_addr_hi", 64'(addr_q[3]), 64'h3FFFF);
         end
      end

      // Reset during HIGH of a write, request held through reset
      bus.mem_write = 1'b1;
      bus.address   = 32'h0000_0020;
      bus.data      = 32'h1111_2222;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("high_we_n", 64'(bus.sram_we_n), 64'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("abort_we_n",   64'(bus.sram_we_n), 64'd1);
      chk("abort_oe",     64'(bus.sram_dq_oe), 64'd0);
      chk("abort_result", 64'(bus.mem_result), 64'd0);
      chk("abort_ready",  64'(bus.ready), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      run(1'b1, 1'b0, 32'h0000_0020, 32'h1111_2222, 32'h0, lat, act);
      chk("restart_latency", 64'(lat), 64'd5);
      chk("restart_addr",    64'(addr_q[0]), 64'h10);
      run(1'b0, 1'b1, 32'h0000_0008, 32'h0, 32'h1234_5678, lat, act);
      chk("post_rst_read_latency", 64'(lat), 64'd5);

      // Read request dropped while in LOW still runs to DONE
      bus.mem_read = 1'b1;
      bus.address  = 32'h0000_0010;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      bus.mem_read = 1'b0;
      seen = 0;
      lat  = -1;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         if (bus.ready) begin
            seen = 1;
            lat  = c;
         end
         @(posedge clk);
         #1;
      end
      chk("drop_done_cycle", 64'(lat), 64'd3);
      @(negedge clk);
      chk("drop_idle_ready",  64'(bus.ready), 64'd1);
      chk("drop_idle_we_n",   64'(bus.sram_we_n), 64'd1);
      chk("drop_idle_addr",   64'(bus.sram_addr), 64'd0);
      chk("drop_result_held", 64'(bus.mem_result), 64'h1234_5678);
      @(posedge clk);
      #1;
      run(1'b0, 1'b1, 32'h0000_0010, 32'h0, 32'hCAFE_F00D, lat, act);
      chk("after_drop_latency", 64'(lat), 64'd5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
